pc_gen_unit: RTL and testbench
==============================

Name: pc_gen_unit

Overview:
Parametrised program-counter generator for the fetch stage, and the successor to the basic PC counter.
- Presents the current PC to fetch over a valid/ready handshake.
- Accepts absolute or PC-relative redirects.
- Detects misaligned redirect targets and raises a fault that fetch must acknowledge, then vectors to a trap address.
- Supports a halt request from the control unit.

Parameters:
XLEN, 32, width of PC and redirect target.
RESET_VEC, 32'h0000_0000, PC value after reset; must be a multiple of ALIGN.
TRAP_VEC, 32'h0000_0100, PC loaded after fault acknowledge; must be a multiple of ALIGN.
INC_BY, 4, sequential increment; must be a multiple of ALIGN.
ALIGN, 4, required PC alignment in bytes; must be a power of two, at least 1.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset, synchronous, active-high.
en_i  in  1  global enable; 0 freezes all state.
redir_valid_i  in  1  redirect request.
redir_rel_i  in  1  1 = target is pc_o + redir_tgt_i; 0 = target is redir_tgt_i.
redir_tgt_i  in  XLEN  redirect target or offset.
pc_ready_i  in  1  fetch accepts pc_o this cycle.
fault_ack_i  in  1  fetch/trap logic acknowledges the fault.
halt_i  in  1  halt request (level).
pc_o  out  XLEN  current PC.
pc_valid_o  out  1  pc_o is valid for fetch.
fault_o  out  1  misaligned-target fault pending.
epc_o  out  XLEN  faulting target address.
halted_o  out  1  unit is in HALT.

Behaviour:
- All state updates occur on posedge clk_i.
- Priority per cycle: rst_i > !en_i (hold) > state logic.
- Reset, taken in any state mid-operation: state=IDLE, pc_o=RESET_VEC, pc_valid_o=0, fault_o=0, epc_o=0, halted_o=0.
- Target computation (combinational):
  - tgt = redir_rel_i ? pc_o + redir_tgt_i : redir_tgt_i, truncated to XLEN (wraps modulo 2^XLEN).
  - Misaligned when tgt[log2(ALIGN)-1:0] != 0; never misaligned when ALIGN=1.
- IDLE:
  - With en_i=1, go to RUN next cycle; pc_valid_o=1; pc_o stays RESET_VEC.
  - redir/halt/ack inputs are ignored.
- RUN (pc_valid_o=1), evaluated in this order:
  1. redir_valid_i with aligned target: pc_o<=tgt; stay in RUN. Overrides the handshake; any unaccepted PC is dropped.
  2. redir_valid_i with misaligned target: epc_o<=tgt, fault_o<=1, pc_valid_o<=0, pc_o held; go to FAULT.
  3. Otherwise, if pc_ready_i: pc_o<=pc_o+INC_BY (wraps at 2^XLEN).
  4. Otherwise, if halt_i is also high: after step 3, go to HALT with pc_valid_o<=0 and halted_o<=1. A PC accepted in the same cycle still advances.
- FAULT:
  - pc_valid_o=0; redirect and halt are ignored.
  - On fault_ack_i: pc_o<=TRAP_VEC, fault_o<=0, pc_valid_o<=1; go to RUN.
  - epc_o holds its value until the next fault or reset.
- HALT:
  - pc_valid_o=0, halted_o=1; pc_o held.
  - When halt_i=0: go to RUN, halted_o<=0, pc_valid_o<=1, pc_o unchanged.
  - Redirects are ignored while in HALT.
- Latency: redirect, advance, and ack all take effect on pc_o one cycle after the request.
- Handshake: pc_o is stable while pc_valid_o=1 and pc_ready_i=0, unless a redirect occurs.
- en_i=0: every register holds, and all request inputs are ignored that cycle.

Decomposition:
- Shared package/include pc_pkg holds:
  - State encoding: IDLE=2'd0, RUN=2'd1, FAULT=2'd2, HALT=2'd3.
  - Localparam ALIGN_BITS=$clog2(ALIGN).
  - Parameter legality checks.
- Sub-module pc_target_calc (combinational): tgt adder/mux plus the misalignment flag. It is reused by the branch unit.

Test Plan:
- Reset then en_i=1, pc_ready_i=1 for 3 cycles -> pc_valid_o 0,1,1,1; pc_o 0x0, 0x0, 0x4, 0x8.
- In RUN at pc_o=0x10, redir_valid_i=1, redir_rel_i=1, redir_tgt_i=0xFFFF_FFF8 (-8) -> next pc_o=0x08. Then redir_rel_i=0, redir_tgt_i=0x200 -> pc_o=0x200.
- Redirect absolute 0x202 -> fault_o=1, epc_o=0x202, pc_valid_o=0; redirect held 3 cycles leaves pc_o unchanged. Then fault_ack_i=1 -> pc_o=0x100, pc_valid_o=1, fault_o=0.
- pc_o=0xFFFF_FFFC with pc_ready_i=1 -> pc_o wraps to 0x0. With pc_ready_i=0 for 4 cycles -> pc_o held at 0x0.
- halt_i=1 with pc_ready_i=1 at pc_o=0x40 -> pc_o=0x44, halted_o=1, pc_valid_o=0. Redirect while halted is ignored. Drop halt_i -> RUN with pc_o=0x44.
- In FAULT, assert rst_i for 1 cycle -> pc_o=0x0, fault_o=0, epc_o=0, halted_o=0, pc_valid_o=0. en_i=0 for 2 cycles mid-RUN -> all outputs frozen.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator and its target calculator.
package pc_pkg;

    // Fetch-side PC generator states; encoding is fixed so other blocks can decode it.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2,
        ST_HALT  = 2'd3
    } pc_state_e;

    // Default alignment and the number of low PC bits it constrains.
    localparam int unsigned DEFAULT_ALIGN = 4;
    localparam int unsigned ALIGN_BITS    = $clog2(DEFAULT_ALIGN);

    // Number of low address bits that must be zero for a given alignment.
    function automatic int unsigned align_bits_f(input int unsigned align);
        return $clog2(align);
    endfunction

    // True when align is a non-zero power of two.
    function automatic bit is_pow2_f(input int unsigned align);
        return (align != 0) && ((align & (align - 1)) == 0);
    endfunction

    // True when value is a multiple of align (align assumed a power of two).
    function automatic bit is_aligned_f(input longint unsigned value, input int unsigned align);
        return (value & longint'(align - 1)) == 0;
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target computation: absolute or PC-relative, plus misalignment flag.
// Kept standalone because the branch unit shares the same arithmetic.
module pc_target_calc
    import pc_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ALIGN_BITS = 2
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            redir_rel_i,
    input  logic [XLEN-1:0] redir_tgt_i,
    output logic [XLEN-1:0] tgt_o,
    output logic            misaligned_o
);

    // Mask of the low bits that must be zero; empty when ALIGN_BITS is 0.
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);

    // Select the target and flag it when any constrained low bit is set; the
    // addition wraps naturally at XLEN bits.
    always_comb begin
        tgt_o        = redir_rel_i ? (pc_i + redir_tgt_i) : redir_tgt_i;
        misaligned_o = |(tgt_o & ALIGN_MASK);
    end

endmodule

// File: rtl/pc_gen_unit.sv
// Program-counter generator for the fetch stage: valid/ready PC handshake,
// absolute/relative redirects, misaligned-target fault with trap vectoring,
// and a level-sensitive halt.
module pc_gen_unit
    import pc_pkg::*;
#(
    parameter int unsigned    XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
    parameter int unsigned    INC_BY    = 4,
    parameter int unsigned    ALIGN     = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic            redir_valid_i,
    input  logic            redir_rel_i,
    input  logic [XLEN-1:0] redir_tgt_i,
    input  logic            pc_ready_i,
    input  logic            fault_ack_i,
    input  logic            halt_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            fault_o,
    output logic [XLEN-1:0] epc_o,
    output logic            halted_o
);

    localparam int unsigned ALIGN_BITS_L = align_bits_f(ALIGN);

    // Reject illegal parameter combinations at elaboration time.
    if (!is_pow2_f(ALIGN) || !is_aligned_f(64'(RESET_VEC), ALIGN) ||
        !is_aligned_f(64'(TRAP_VEC), ALIGN) || !is_aligned_f(64'(INC_BY), ALIGN) ||
        XLEN == 0 || XLEN > 64) begin : g_bad_params
        $fatal(1, "pc_gen_unit: illegal XLEN/ALIGN/RESET_VEC/TRAP_VEC/INC_BY");
    end

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_valid_q, pc_valid_d;
    logic            fault_q, fault_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            halted_q, halted_d;

    logic [XLEN-1:0] tgt;
    logic            tgt_misaligned;

    pc_target_calc #(
        .XLEN       (XLEN),
        .ALIGN_BITS (ALIGN_BITS_L)
    ) u_target_calc (
        .pc_i         (pc_q),
        .redir_rel_i  (redir_rel_i),
        .redir_tgt_i  (redir_tgt_i),
        .tgt_o        (tgt),
        .misaligned_o (tgt_misaligned)
    );

    // Next-state and next-output logic; with en_i low everything holds.
    always_comb begin
        // NOTE: every _d gets its hold value first so no path leaves one unassigned, which would infer a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        fault_d    = fault_q;
        epc_d      = epc_q;
        halted_d   = halted_q;

        if (en_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d    = ST_RUN;
                    pc_valid_d = 1'b1;
                end

                ST_RUN: begin
                    if (redir_valid_i && !tgt_misaligned) begin
                        // Redirect wins over the handshake; an unaccepted PC is dropped.
                        pc_d = tgt;
                    end else if (redir_valid_i) begin
                        epc_d      = tgt;
                        fault_d    = 1'b1;
                        pc_valid_d = 1'b0;
                        state_d    = ST_FAULT;
                    end else begin
                        if (pc_ready_i) begin
                            pc_d = pc_q + XLEN'(INC_BY);
                        end
                        // A PC accepted in the halting cycle still advances.
                        if (halt_i) begin
                            pc_valid_d = 1'b0;
                            halted_d   = 1'b1;
                            state_d    = ST_HALT;
                        end
                    end
                end

                ST_FAULT: begin
                    if (fault_ack_i) begin
                        pc_d       = TRAP_VEC;
                        fault_d    = 1'b0;
                        pc_valid_d = 1'b1;
                        state_d    = ST_RUN;
                    end
                end

                ST_HALT: begin
                    if (!halt_i) begin
                        halted_d   = 1'b0;
                        pc_valid_d = 1'b1;
                        state_d    = ST_RUN;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments make every register sample the pre-edge values, avoiding simulation races.
        if (rst_i) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_VEC;
            pc_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            epc_q      <= '0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            fault_q    <= fault_d;
            epc_q      <= epc_d;
            halted_q   <= halted_d;
        end
    end

    assign pc_o       = pc_q;
    assign pc_valid_o = pc_valid_q;
    assign fault_o    = fault_q;
    assign epc_o      = epc_q;
    assign halted_o   = halted_q;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed testbench for pc_gen_unit with default parameters.
module tb_pc_gen_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic        redir_valid_i;
    logic        redir_rel_i;
    logic [31:0] redir_tgt_i;
    logic        pc_ready_i;
    logic        fault_ack_i;
    logic        halt_i;
    logic [31:0] pc_o;
    logic        pc_valid_o;
    logic        fault_o;
    logic [31:0] epc_o;
    logic        halted_o;

    int passed = 0;
    int total  = 0;

    pc_gen_unit #(
        .XLEN      (32),
        .RESET_VEC (32'h0000_0000),
        .TRAP_VEC  (32'h0000_0100),
        .INC_BY    (4),
        .ALIGN     (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .redir_valid_i (redir_valid_i),
        .redir_rel_i   (redir_rel_i),
        .redir_tgt_i   (redir_tgt_i),
        .pc_ready_i    (pc_ready_i),
        .fault_ack_i   (fault_ack_i),
        .halt_i        (halt_i),
        .pc_o          (pc_o),
        .pc_valid_o    (pc_valid_o),
        .fault_o       (fault_o),
        .epc_o         (epc_o),
        .halted_o      (halted_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic redirect(input logic rel, input logic [31:0] tgt);
        redir_valid_i = 1'b1;
        redir_rel_i   = rel;
        redir_tgt_i   = tgt;
    endtask

    task automatic no_redirect();
        redir_valid_i = 1'b0;
        redir_rel_i   = 1'b0;
        redir_tgt_i   = 32'h0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; en_i = 1'b0; pc_ready_i = 1'b0; fault_ack_i = 1'b0; halt_i = 1'b0;
        no_redirect();
        step(); step();
        rst_i = 1'b0;
        total++; if (pc_o !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc_o, 32'h0); else passed++;
        total++; if (pc_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", pc_valid_o); else passed++;
        total++; if (fault_o !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault_o); else passed++;
        total++; if (epc_o !== 32'h0) $display("FAIL reset_epc: got %h want %h", epc_o, 32'h0); else passed++;
        total++; if (halted_o !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted_o); else passed++;
    endtask

    // IDLE -> RUN then two accepted PCs: valid 0,1,1,1 and pc 0,0,4,8.
    task automatic test_sequential();
        en_i = 1'b1; pc_ready_i = 1'b1;
        step();
        total++; if (pc_valid_o !== 1'b1 || pc_o !== 32'h0) $display("FAIL seq_c1: got v=%b pc=%h want v=1 pc=%h", pc_valid_o, pc_o, 32'h0); else passed++;
        step();
        total++; if (pc_valid_o !== 1'b1 || pc_o !== 32'h4) $display("FAIL seq_c2: got v=%b pc=%h want v=1 pc=%h", pc_valid_o, pc_o, 32'h4); else passed++;
        step();
        total++; if (pc_valid_o !== 1'b1 || pc_o !== 32'h8) $display("FAIL seq_c3: got v=%b pc=%h want v=1 pc=%h", pc_valid_o, pc_o, 32'h8); else passed++;
    endtask

    // Relative -8 from 0x10, then absolute 0x200.
    task automatic test_redirect();
        step(); step();
        total++; if (pc_o !== 32'h10) $display("FAIL redir_setup: got %h want %h", pc_o, 32'h10); else passed++;
        pc_ready_i = 1'b0;
        redirect(1'b1, 32'hFFFF_FFF8);
        step();
        total++; if (pc_o !== 32'h08) $display("FAIL redir_rel: got %h want %h", pc_o, 32'h08); else passed++;
        redirect(1'b0, 32'h0000_0200);
        step();
        total++; if (pc_o !== 32'h200) $display("FAIL redir_abs: got %h want %h", pc_o, 32'h200); else passed++;
        total++; if (pc_valid_o !== 1'b1) $display("FAIL redir_valid: got %b want 1", pc_valid_o); else passed++;
    endtask

    // Misaligned absolute target faults; redirects are ignored until acknowledge.
    task automatic test_fault();
        redirect(1'b0, 32'h0000_0202);
        step();
        total++; if (fault_o !== 1'b1) $display("FAIL fault_set: got %b want 1", fault_o); else passed++;
        total++; if (epc_o !== 32'h202) $display("FAIL fault_epc: got %h want %h", epc_o, 32'h202); else passed++;
        total++; if (pc_valid_o !== 1'b0) $display("FAIL fault_valid: got %b want 0", pc_valid_o); else passed++;
        total++; if (pc_o !== 32'h200) $display("FAIL fault_pc: got %h want %h", pc_o, 32'h200); else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (pc_o !== 32'h200 || fault_o !== 1'b1) $display("FAIL fault_hold%0d: got pc=%h f=%b want pc=%h f=1", i, pc_o, fault_o, 32'h200); else passed++;
        end
        no_redirect();
        fault_ack_i = 1'b1;
        step();
        fault_ack_i = 1'b0;
        total++; if (pc_o !== 32'h100) $display("FAIL ack_pc: got %h want %h", pc_o, 32'h100); else passed++;
        total++; if (pc_valid_o !== 1'b1 || fault_o !== 1'b0) $display("FAIL ack_flags: got v=%b f=%b want v=1 f=0", pc_valid_o, fault_o); else passed++;
        total++; if (epc_o !== 32'h202) $display("FAIL ack_epc: got %h want %h", epc_o, 32'h202); else passed++;
    endtask

    // Advance past the top of the address space, then hold with no ready.
    task automatic test_wrap();
        redirect(1'b0, 32'hFFFF_FFFC);
        step();
        no_redirect();
        total++; if (pc_o !== 32'hFFFF_FFFC) $display("FAIL wrap_setup: got %h want %h", pc_o, 32'hFFFF_FFFC); else passed++;
        pc_ready_i = 1'b1;
        step();
        pc_ready_i = 1'b0;
        total++; if (pc_o !== 32'h0) $display("FAIL wrap_pc: got %h want %h", pc_o, 32'h0); else passed++;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (pc_o !== 32'h0 || pc_valid_o !== 1'b1) $display("FAIL stall%0d: got pc=%h v=%b want pc=%h v=1", i, pc_o, pc_valid_o, 32'h0); else passed++;
        end
    endtask

    // Halt with a same-cycle accept, ignored redirect, then resume.
    task automatic test_halt();
        redirect(1'b0, 32'h0000_0040);
        step();
        no_redirect();
        halt_i = 1'b1; pc_ready_i = 1'b1;
        step();
        pc_ready_i = 1'b0;
        total++; if (pc_o !== 32'h44) $display("FAIL halt_pc: got %h want %h", pc_o, 32'h44); else passed++;
        total++; if (halted_o !== 1'b1 || pc_valid_o !== 1'b0) $display("FAIL halt_flags: got h=%b v=%b want h=1 v=0", halted_o, pc_valid_o); else passed++;
        redirect(1'b0, 32'h0000_0080);
        step();
        no_redirect();
        total++; if (pc_o !== 32'h44 || halted_o !== 1'b1) $display("FAIL halt_redir: got pc=%h h=%b want pc=%h h=1", pc_o, halted_o, 32'h44); else passed++;
        halt_i = 1'b0;
        step();
        total++; if (pc_o !== 32'h44 || halted_o !== 1'b0 || pc_valid_o !== 1'b1) $display("FAIL resume: got pc=%h h=%b v=%b want pc=%h h=0 v=1", pc_o, halted_o, pc_valid_o, 32'h44); else passed++;
    endtask

    // en_i low freezes everything even with active requests.
    task automatic test_enable();
        en_i = 1'b0; pc_ready_i = 1'b1; halt_i = 1'b1;
        redirect(1'b0, 32'h0000_0082);
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (pc_o !== 32'h44 || pc_valid_o !== 1'b1 || fault_o !== 1'b0 || halted_o !== 1'b0 || epc_o !== 32'h202)
                $display("FAIL freeze%0d: got pc=%h v=%b f=%b h=%b epc=%h want pc=%h v=1 f=0 h=0 epc=%h", i, pc_o, pc_valid_o, fault_o, halted_o, epc_o, 32'h44, 32'h202);
            else passed++;
        end
        no_redirect();
        halt_i = 1'b0; en_i = 1'b1;
        step();
        pc_ready_i = 1'b0;
        total++; if (pc_o !== 32'h48) $display("FAIL unfreeze: got %h want %h", pc_o, 32'h48); else passed++;
    endtask

    // Reset taken while a fault is pending, then restart from IDLE.
    task automatic test_reset_in_fault();
        redirect(1'b1, 32'h0000_0001);
        step();
        no_redirect();
        total++; if (fault_o !== 1'b1 || epc_o !== 32'h49) $display("FAIL rel_fault: got f=%b epc=%h want f=1 epc=%h", fault_o, epc_o, 32'h49); else passed++;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        total++; if (pc_o !== 32'h0 || epc_o !== 32'h0) $display("FAIL rst_fault_regs: got pc=%h epc=%h want 0 0", pc_o, epc_o); else passed++;
        total++; if (fault_o !== 1'b0 || halted_o !== 1'b0 || pc_valid_o !== 1'b0) $display("FAIL rst_fault_flags: got f=%b h=%b v=%b want 0 0 0", fault_o, halted_o, pc_valid_o); else passed++;
        step();
        total++; if (pc_valid_o !== 1'b1 || pc_o !== 32'h0) $display("FAIL restart: got v=%b pc=%h want v=1 pc=%h", pc_valid_o, pc_o, 32'h0); else passed++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect();
        test_fault();
        test_wrap();
        test_halt();
        test_enable();
        test_reset_in_fault();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
